// File: rtl/boardtest_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : boardtest_gen_if
// Brief    : Front-panel, reference and indicator signals of the board test
//            block, grouped for the top-level hookup.
// Revision : 1.0 - initial release
// ============================================================================
interface boardtest_gen_if #(
    parameter int N_LED  = 4,
    parameter int N_BTN  = 4,
    parameter int MEAS_W = 24
);
    logic [N_BTN-1:0]  BTN;
    logic              DIR;
    logic              REFIN;
    logic [N_LED-1:0]  LED;
    logic [N_BTN-1:0]  BTN_PRESS;
    logic [N_BTN-1:0]  BTN_TGL;
    logic              REFOUT;
    logic [MEAS_W-1:0] REF_PERIOD;
    logic              REF_VALID;
    logic              REF_TIMEOUT;
    logic              SCLK;

    modport master (
        output BTN, DIR, REFIN,
        input  LED, BTN_PRESS, BTN_TGL, REFOUT, REF_PERIOD, REF_VALID,
               REF_TIMEOUT, SCLK
    );

    modport slave (
        input  BTN, DIR, REFIN,
        output LED, BTN_PRESS, BTN_TGL, REFOUT, REF_PERIOD, REF_VALID,
               REF_TIMEOUT, SCLK
    );
endinterface
`default_nettype wire

// File: rtl/boardtest_gen.sv
`default_nettype none
// ============================================================================
// Module   : boardtest_gen
// Brief    : Board bring-up block: LED chaser, debounced buttons, reference
//            edge detect / divide / period meter, and a divided test clock.
// Revision : 1.0 - initial release
// ============================================================================
module boardtest_gen #(
    parameter int N_LED     = 4,
    parameter int LED_DIV_W = 23,
    parameter int N_BTN     = 4,
    parameter int DEB_MAX   = 65535,
    parameter int MEAS_W    = 24,
    parameter int SCLK_DIV  = 1
) (
    input  logic           CLK36,
    input  logic           RST,
    boardtest_gen_if.slave bus
);
    localparam int DEB_W  = (DEB_MAX > 1) ? $clog2(DEB_MAX) : 1;
    localparam int SCLK_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    localparam logic [LED_DIV_W-1:0] LED_CNT_ONE = LED_DIV_W'(1);
    localparam logic [N_LED-1:0]     LED_INIT    = N_LED'(1);
    localparam logic [DEB_W-1:0]     DEB_LAST    = DEB_W'(DEB_MAX - 1);
    localparam logic [DEB_W-1:0]     DEB_ONE     = DEB_W'(1);
    localparam logic [MEAS_W-1:0]    PCNT_SAT    = '1;
    localparam logic [MEAS_W-1:0]    PCNT_ONE    = MEAS_W'(1);
    localparam logic [SCLK_W-1:0]    SCLK_LAST   = SCLK_W'(SCLK_DIV - 1);
    localparam logic [SCLK_W-1:0]    SCLK_ONE    = SCLK_W'(1);

    // ------------------------------------------------------------------
    // LED chaser
    // ------------------------------------------------------------------
    logic [LED_DIV_W-1:0] led_cnt;
    logic [N_LED-1:0]     led;

    always_ff @(posedge CLK36) begin
        if (RST) begin
            led_cnt <= '0;
            led     <= LED_INIT;
        end else begin
            led_cnt <= led_cnt + LED_CNT_ONE;
            // Pure rotation keeps the pattern one-hot without any repair logic.
            if (&led_cnt) begin
                if (bus.DIR) begin
                    led <= {led[0], led[N_LED-1:1]};
                end else begin
                    led <= {led[N_LED-2:0], led[N_LED-1]};
                end
            end
        end
    end

    assign bus.LED = led;

    // ------------------------------------------------------------------
    // Button synchronise / debounce, one independent lane per button
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_tgl;

    for (genvar b = 0; b < N_BTN; b++) begin : g_btn
        logic             btn_s1;
        logic             btn_s2;
        logic             stable;
        logic [DEB_W-1:0] deb_cnt;
        logic             press;
        logic             tgl;

        always_ff @(posedge CLK36) begin
            if (RST) begin
                btn_s1  <= 1'b1;
                btn_s2  <= 1'b1;
                stable  <= 1'b1;
                deb_cnt <= '0;
                press   <= 1'b0;
                tgl     <= 1'b0;
            end else begin
                btn_s1 <= bus.BTN[b];
                btn_s2 <= btn_s1;
                press  <= 1'b0;
                if (btn_s2 == stable) begin
                    deb_cnt <= '0;
                end else if (deb_cnt == DEB_LAST) begin
                    stable  <= btn_s2;
                    deb_cnt <= '0;
                    // Only the released-to-pressed transition is reported.
                    if (stable) begin
                        press <= 1'b1;
                        tgl   <= ~tgl;
                    end
                end else begin
                    deb_cnt <= deb_cnt + DEB_ONE;
                end
            end
        end

        assign btn_press[b] = press;
        assign btn_tgl[b]   = tgl;
    end

    assign bus.BTN_PRESS = btn_press;
    assign bus.BTN_TGL   = btn_tgl;

    // ------------------------------------------------------------------
    // Reference input: synchronise, edge detect, divide, measure period
    // ------------------------------------------------------------------
    logic              ref_s1;
    logic              ref_s2;
    logic              ref_dly;
    logic              ref_rise;
    logic [MEAS_W-1:0] pcnt;
    logic              armed;
    logic              refout;
    logic [MEAS_W-1:0] ref_period;
    logic              ref_valid;
    logic              ref_timeout;

    assign ref_rise = ref_s2 & ~ref_dly;

    always_ff @(posedge CLK36) begin
        if (RST) begin
            ref_s1      <= 1'b0;
            ref_s2      <= 1'b0;
            ref_dly     <= 1'b0;
            pcnt        <= '0;
            armed       <= 1'b0;
            refout      <= 1'b0;
            ref_period  <= '0;
            ref_valid   <= 1'b0;
            ref_timeout <= 1'b0;
        end else begin
            ref_s1    <= bus.REFIN;
            ref_s2    <= ref_s1;
            ref_dly   <= ref_s2;
            ref_valid <= 1'b0;
            if (ref_rise) begin
                refout      <= ~refout;
                pcnt        <= PCNT_ONE;
                armed       <= 1'b1;
                ref_timeout <= 1'b0;
                // A saturated count means the interval is unknown: re-arm only.
                if (armed && (pcnt != PCNT_SAT)) begin
                    ref_period <= pcnt;
                    ref_valid  <= 1'b1;
                end
            end else begin
                if (pcnt != PCNT_SAT) begin
                    pcnt <= pcnt + PCNT_ONE;
                end else begin
                    ref_timeout <= 1'b1;
                end
            end
        end
    end

    assign bus.REFOUT      = refout;
    assign bus.REF_PERIOD  = ref_period;
    assign bus.REF_VALID   = ref_valid;
    assign bus.REF_TIMEOUT = ref_timeout;

    // ------------------------------------------------------------------
    // Free-running test clock
    // ------------------------------------------------------------------
    logic [SCLK_W-1:0] sclk_cnt;
    logic              sclk;

    always_ff @(posedge CLK36) begin
        if (RST) begin
            sclk_cnt <= '0;
            sclk     <= 1'b0;
        end else if (sclk_cnt == SCLK_LAST) begin
            sclk_cnt <= '0;
            sclk     <= ~sclk;
        end else begin
            sclk_cnt <= sclk_cnt + SCLK_ONE;
        end
    end

    assign bus.SCLK = sclk;

endmodule
`default_nettype wire

// File: tb/tb_boardtest_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_boardtest_gen
// Brief    : Directed + randomised stimulus for boardtest_gen, checked every
//            cycle against a cycle-stamp based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_boardtest_gen;
    localparam int N_LED     = 4;
    localparam int LED_DIV_W = 3;
    localparam int N_BTN     = 4;
    localparam int DEB_MAX   = 4;
    localparam int MEAS_W    = 8;
    localparam int SCLK_DIV  = 3;
    localparam int LED_STEP  = 1 << LED_DIV_W;
    localparam int SAT       = (1 << MEAS_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    boardtest_gen_if #(.N_LED(N_LED), .N_BTN(N_BTN), .MEAS_W(MEAS_W)) bus ();

    boardtest_gen #(
        .N_LED(N_LED), .LED_DIV_W(LED_DIV_W), .N_BTN(N_BTN),
        .DEB_MAX(DEB_MAX), .MEAS_W(MEAS_W), .SCLK_DIV(SCLK_DIV)
    ) dut (
        .CLK36(clk),
        .RST  (rst),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: everything is expressed in clock-edge stamps since the
    // last reset edge and in raw input-sample histories.
    int               cyc = 0;
    int               rst_cyc = 0;
    int               led_pos = 0;
    int               last_edge = 0;
    int               since_rst;
    bit               armed = 1'b0;
    logic [N_BTN-1:0] btn_q[$];
    logic             ref_q[$];
    logic [N_BTN-1:0] m_stable;
    logic [N_BTN-1:0] exp_press, exp_tgl;
    logic [N_LED-1:0] exp_led;
    logic [MEAS_W-1:0] exp_period;
    logic             exp_refout, exp_valid, exp_timeout, exp_sclk;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            rst_cyc = cyc;
            led_pos = 0;
            m_stable = '1;
            exp_press = '0;
            exp_tgl = '0;
            btn_q.delete();
            for (int i = 0; i < DEB_MAX + 2; i++) btn_q.push_front('1);
            ref_q.delete();
            for (int i = 0; i < 4; i++) ref_q.push_front(1'b0);
            armed = 1'b0;
            last_edge = cyc + 1;
            exp_refout = 1'b0;
            exp_period = '0;
            exp_valid = 1'b0;
            exp_timeout = 1'b0;
        end else begin
            since_rst = cyc - rst_cyc;
            if (since_rst % LED_STEP == 0)
                led_pos = bus.DIR ? (led_pos + N_LED - 1) % N_LED : (led_pos + 1) % N_LED;

            // A press is accepted once DEB_MAX consecutive synchronised
            // samples (two clocks old) all disagree with the stable state.
            btn_q.push_front(bus.BTN);
            void'(btn_q.pop_back());
            exp_press = '0;
            for (int b = 0; b < N_BTN; b++) begin
                bit               all_diff;
                logic [N_BTN-1:0] smp;
                all_diff = 1'b1;
                for (int i = 2; i < DEB_MAX + 2; i++) begin
                    smp = btn_q[i];
                    if (smp[b] == m_stable[b]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_stable[b] = ~m_stable[b];
                    if (!m_stable[b]) begin
                        exp_press[b] = 1'b1;
                        exp_tgl[b] = ~exp_tgl[b];
                    end
                end
            end

            ref_q.push_front(bus.REFIN);
            void'(ref_q.pop_back());
            exp_valid = 1'b0;
            if (ref_q[2] && !ref_q[3]) begin
                exp_refout = ~exp_refout;
                if (armed && (cyc - last_edge) < SAT) begin
                    exp_period = MEAS_W'(cyc - last_edge);
                    exp_valid = 1'b1;
                end
                armed = 1'b1;
                last_edge = cyc;
                exp_timeout = 1'b0;
            end else if (cyc - last_edge >= SAT) begin
                exp_timeout = 1'b1;
            end
        end
        exp_led = '0;
        exp_led[led_pos] = 1'b1;
        exp_sclk = (((cyc - rst_cyc) / SCLK_DIV) % 2) == 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        chk("led",     32'(bus.LED),         32'(exp_led));
        chk("press",   32'(bus.BTN_PRESS),   32'(exp_press));
        chk("tgl",     32'(bus.BTN_TGL),     32'(exp_tgl));
        chk("refout",  32'(bus.REFOUT),      32'(exp_refout));
        chk("period",  32'(bus.REF_PERIOD),  32'(exp_period));
        chk("valid",   32'(bus.REF_VALID),   32'(exp_valid));
        chk("timeout", 32'(bus.REF_TIMEOUT), 32'(exp_timeout));
        chk("sclk",    32'(bus.SCLK),        32'(exp_sclk));
    endtask

    task automatic ref_wave(input int p);
        bus.REFIN = 1'b1;
        repeat (p / 2) step();
        bus.REFIN = 1'b0;
        repeat (p - p / 2) step();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_led"},     32'(bus.LED),         32'd1);
        chk({tag, "_press"},   32'(bus.BTN_PRESS),   32'd0);
        chk({tag, "_tgl"},     32'(bus.BTN_TGL),     32'd0);
        chk({tag, "_refout"},  32'(bus.REFOUT),      32'd0);
        chk({tag, "_period"},  32'(bus.REF_PERIOD),  32'd0);
        chk({tag, "_valid"},   32'(bus.REF_VALID),   32'd0);
        chk({tag, "_timeout"}, 32'(bus.REF_TIMEOUT), 32'd0);
        chk({tag, "_sclk"},    32'(bus.SCLK),        32'd0);
    endtask

    int lat;
    int nvalid;

    initial begin
        bus.BTN   = '1;
        bus.DIR   = 1'b0;
        bus.REFIN = 1'b0;
        rst       = 1'b1;
        repeat (2) step();
        chk_reset_state("rst0");
        rst = 1'b0;

        // Chaser: 8 clocks per step, direction change mid-period, then random.
        repeat (7) step();
        chk("led_hold", 32'(bus.LED), 32'd1);
        step();
        chk("led_step1", 32'(bus.LED), 32'd2);
        repeat (29) step();
        bus.DIR = 1'b1;
        repeat (40) step();
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) bus.DIR = 1'($urandom_range(0, 1));
            step();
        end

        // Clean press on BTN[0]: 2 + DEB_MAX cycles to the pulse.
        bus.BTN[0] = 1'b0;
        lat = 0;
        do begin
            step();
            lat++;
        end while (bus.BTN_PRESS[0] !== 1'b1 && lat < 20);
        chk("press_latency", 32'(lat), 32'(2 + DEB_MAX));
        chk("tgl_first", 32'(bus.BTN_TGL[0]), 32'd1);
        repeat (6) step();
        bus.BTN[0] = 1'b1;
        repeat (12) step();
        bus.BTN[0] = 1'b0;
        repeat (12) step();
        chk("tgl_second", 32'(bus.BTN_TGL[0]), 32'd0);
        bus.BTN[0] = 1'b1;
        repeat (12) step();

        // Bouncing BTN[1]: 3 low / 1 high never reaches DEB_MAX.
        repeat (4) begin
            bus.BTN[1] = 1'b0;
            repeat (3) step();
            bus.BTN[1] = 1'b1;
            step();
        end
        bus.BTN[1] = 1'b0;
        repeat (12) step();
        bus.BTN[1] = 1'b1;
        repeat (10) step();

        // Random button activity with hold times around the debounce length.
        repeat (150) begin
            bus.BTN = N_BTN'($urandom);
            repeat ($urandom_range(1, 7)) step();
        end
        bus.BTN = '1;
        repeat (10) step();

        // 100-clock square wave on REFIN.
        nvalid = 0;
        repeat (5) begin
            ref_wave(100);
            if (bus.REF_VALID === 1'b1) nvalid++;
        end
        chk("period_100", 32'(bus.REF_PERIOD), 32'd100);

        // Long gap -> sticky timeout; next edge only re-arms.
        bus.REFIN = 1'b1;
        repeat (10) step();
        bus.REFIN = 1'b0;
        repeat (300) step();
        chk("timeout_set", 32'(bus.REF_TIMEOUT), 32'd1);
        repeat (3) ref_wave(60);
        chk("period_after_to", 32'(bus.REF_PERIOD), 32'd60);

        // Random periods, including some across the saturation point.
        repeat (14) ref_wave($urandom_range(4, 270));

        // Reset in the middle of a debounce and a measurement.
        repeat (2) ref_wave(50);
        bus.REFIN = 1'b1;
        repeat (2) step();
        bus.BTN[2] = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        chk_reset_state("rst_mid");
        rst = 1'b0;
        repeat (20) step();
        bus.BTN[2] = 1'b1;
        bus.REFIN = 1'b0;
        repeat (20) step();
        repeat (3) ref_wave(40);
        chk("period_after_rst", 32'(bus.REF_PERIOD), 32'd40);
        repeat (12) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/boardtest_gen.md
Name: boardtest_gen

Overview:
Parametrised board bring-up block for the lock-in FPGA board. It drives a rotating one-hot LED pattern with selectable direction. It debounces N active-low front-panel buttons into press pulses and toggle outputs. It synchronises and edge-detects the reference input, mirrors it as a divided-by-2 REFOUT, and measures the reference period in clock cycles. It also generates a free-running SCLK test clock with programmable division. It sits at top level in place of the fixed 4-LED/2-button test logic.

Parameters:
N_LED, 4, number of LEDs in the one-hot chaser (>=2)
LED_DIV_W, 23, chaser step period = 2^LED_DIV_W clocks
N_BTN, 4, number of active-low button inputs (>=1)
DEB_MAX, 65535, consecutive mismatching cycles required to accept a button change (>=1)
MEAS_W, 24, width of reference period counter/result
SCLK_DIV, 1, SCLK half-period in clocks (>=1)

Ports:
CLK36  in  1  system clock, 36 MHz
RST  in  1  synchronous reset, active-high
BTN  in  N_BTN  raw buttons, active-low, asynchronous
DIR  in  1  chaser direction: 0 = toward MSB, 1 = toward LSB
REFIN  in  1  raw reference input, asynchronous
LED  out  N_LED  one-hot chaser
BTN_PRESS  out  N_BTN  one-cycle pulse per accepted press
BTN_TGL  out  N_BTN  toggles on each accepted press
REFOUT  out  1  toggles on each REFIN rising edge
REF_PERIOD  out  MEAS_W  last measured rising-to-rising period, in clocks
REF_VALID  out  1  one-cycle pulse when REF_PERIOD updates
REF_TIMEOUT  out  1  sticky: no REFIN edge for 2^MEAS_W-1 clocks
SCLK  out  1  divided test clock

Behaviour:
- Reset (RST high at a CLK36 edge):
  - LED=1 (bit0). BTN_PRESS=0, BTN_TGL=0, REFOUT=0, REF_PERIOD=0, REF_VALID=0, REF_TIMEOUT=0, SCLK=0.
  - All counters = 0.
  - Button sync/stable regs = 1 (released). REF sync regs = 0. Measurement disarmed.
  - Reset mid-operation discards partial debounce counts and period measurement.
- Chaser:
  - LED_DIV_W-bit counter increments every cycle and wraps.
  - On the cycle the counter is all-ones, LED rotates one position. DIR=0: bit i -> i+1, MSB -> bit0. DIR=1: reverse.
  - DIR is sampled only at the rotate edge. LED is always exactly one-hot.
- Buttons (per bit, independent):
  - 2-FF synchroniser, then a debounce counter against the stable state.
  - Synced == stable: counter cleared.
  - Synced != stable: counter increments. On the edge where counter == DEB_MAX-1 and still mismatched, stable <= synced and the counter clears.
  - Any bounce back before acceptance clears the counter.
  - Stable 1->0 transition: BTN_PRESS high for exactly the next cycle, and BTN_TGL inverts on that same edge. A 0->1 release produces no pulse.
  - Latency from a clean BTN fall to BTN_PRESS high = 2 + DEB_MAX cycles.
- Reference:
  - 2-FF synchroniser plus one delay reg. Rising edge = sync & ~delay, at 3-cycle latency from REFIN. REFOUT toggles on the edge after detection.
  - pcnt: on an edge pcnt <= 1; otherwise pcnt <= pcnt+1, saturating at all-ones.
  - When pcnt reaches all-ones, REF_TIMEOUT <= 1 and stays high until the next edge clears it.
  - On an edge with measurement armed and pcnt not saturated: REF_PERIOD <= pcnt and REF_VALID pulses for one cycle.
  - The first edge after reset, and the first edge after a timeout, only arm the measurement. Neither produces REF_VALID.
  - Resulting REF_PERIOD = number of clocks between consecutive rising edges.
- SCLK: counter 0..SCLK_DIV-1. SCLK toggles when the counter hits SCLK_DIV-1, then the counter wraps to 0. SCLK_DIV=1 gives CLK36/2.
- All outputs registered; no combinational path from any input to any output.

Test Plan:
- Reset then LED_DIV_W=3, N_LED=4, DIR=0 -> LED=0001 for 8 clocks after reset release, then 0010, 0100, 1000, 0001; switch DIR=1 mid-period -> next step goes 0001->1000.
- DEB_MAX=4, BTN[0] driven low cleanly -> BTN_PRESS[0] single pulse 6 cycles after the fall, BTN_TGL[0] 0->1; release -> no pulse; second press -> BTN_TGL[0] back to 0.
- DEB_MAX=4, BTN[1] bounces low 3 cycles / high 1 cycle repeatedly, then held low -> no pulse during the bounce; exactly one pulse 4 cycles after the last synced fall; other bits stay 0.
- REFIN square wave with a 100-clock period -> REFOUT toggles every 100 clocks; no REF_VALID at the first edge; REF_VALID at every later edge with REF_PERIOD=100.
- MEAS_W=8, REFIN held 0 for 300 clocks after an edge -> REF_TIMEOUT high 255 clocks after the edge; the next edge clears it with no REF_VALID; the following edge reports the correct period.
- Assert RST for 1 cycle mid-debounce and mid-measurement -> all outputs return to reset values; the next REFIN edge only arms; SCLK=0 and restarts with SCLK_DIV=3 giving a 6-clock period.
